// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: code sizes, bit positions, encoder
// function and the transmit FSM state type.
package hamming_pkg;

    localparam int N = 7;
    localparam int K = 4;

    // Data bit positions inside the codeword {c6..c0}
    localparam int D0_POS = 3;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;

    // Parity bit positions
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;

    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    typedef logic [N-1:0] codeword_t;
    typedef logic [K-1:0] dataword_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_t;

    // Parity equations chosen so the downstream decoder sees syndrome 0
    function automatic codeword_t hamming_encode(input dataword_t d);
        codeword_t c;
        c         = '0;
        c[D3_POS] = d[3];
        c[D2_POS] = d[2];
        c[D1_POS] = d[1];
        c[D0_POS] = d[0];
        c[P2_POS] = d[3] ^ d[0] ^ d[1];
        c[P1_POS] = d[3] ^ d[0] ^ d[2];
        c[P0_POS] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming74_enc.sv
// Purely combinational Hamming(7,4) encoder.
module hamming74_enc
    import hamming_pkg::*;
(
    input  logic [K-1:0] d,
    output logic [N-1:0] c
);

    assign c = hamming_encode(d);

endmodule

// File: rtl/hamming_enc_tx.sv
// Transmit-side Hamming(7,4) stage: encode accepted words into a one-word
// hold register, then serialize each codeword one bit per bit_tick with
// start/end-of-frame markers. Hold + shifter allow gap-free frames.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | no frame on the line; load shifter as soon as hold is full
//   ST_SHIFT | frame bit idx_q on ser_out; advance on bit_tick
module hamming_enc_tx
    import hamming_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d_in,
    input  logic       d_valid,
    output logic       d_ready,
    input  logic       bit_tick,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_sof,
    output logic       ser_eof,
    output logic [6:0] c_out,
    output logic [7:0] frame_cnt
);

    tx_state_t  state_q, state_d;
    logic [6:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       rdy_en_q, rdy_en_d;

    logic [6:0] enc_cw;
    logic       accept;
    logic       cur_bit;

    hamming74_enc u_enc (
        .d (d_in),
        .c (enc_cw)
    );

    // rdy_en_q keeps d_ready low through reset and for the release edge
    assign d_ready = rdy_en_q & ~hold_full_q;
    assign accept  = d_valid & d_ready;

    // Next-state logic: hold register fill, FSM, shifter and frame counter
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        rdy_en_d    = 1'b1;

        // d_ready is low whenever hold is full, so accept never collides
        // with a hold-to-shifter transfer below
        if (accept) begin
            hold_d      = enc_cw;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    idx_d       = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_tick) begin
                    if (idx_q == LAST_IDX) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            idx_d       = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

    // Serial bit select according to transmit order
    always_comb begin
        if (MSB_FIRST) begin
            cur_bit = shift_q[LAST_IDX - idx_q];
        end else begin
            cur_bit = shift_q[idx_q];
        end
    end

    assign ser_valid = (state_q == ST_SHIFT);
    assign ser_out   = ser_valid & cur_bit;
    assign ser_sof   = ser_valid & (idx_q == 3'd0);
    assign ser_eof   = ser_valid & (idx_q == LAST_IDX);
    assign c_out     = shift_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hamming_enc_tx.sv
// Self-checking bench for hamming_enc_tx: one MSB-first and one LSB-first
// instance share all inputs; captured serial frames are compared against a
// parity-mask reference model.
module tb_hamming_enc_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d_in;
    logic       d_valid;
    logic       bit_tick;

    logic       m_d_ready, m_ser_out, m_ser_valid, m_ser_sof, m_ser_eof;
    logic [6:0] m_c_out;
    logic [7:0] m_frame_cnt;
    logic       l_d_ready, l_ser_out, l_ser_valid, l_ser_sof, l_ser_eof;
    logic [6:0] l_c_out;
    logic [7:0] l_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] word_q[$];
    logic [3:0] sent_q[$];
    logic       bit_m[$], bit_l[$], sof_m[$], eof_m[$];
    int         held_l[$];
    logic [6:0] cw_m[$], cw_l[$];
    int         valid_m, bursts_m, rdy_low, both_hi, ready_diff;
    bit         timeout;

    always #5 clk = ~clk;

    hamming_enc_tx #(.MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid),
        .d_ready(m_d_ready), .bit_tick(bit_tick), .ser_out(m_ser_out),
        .ser_valid(m_ser_valid), .ser_sof(m_ser_sof), .ser_eof(m_ser_eof),
        .c_out(m_c_out), .frame_cnt(m_frame_cnt)
    );

    hamming_enc_tx #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid),
        .d_ready(l_d_ready), .bit_tick(bit_tick), .ser_out(l_ser_out),
        .ser_valid(l_ser_valid), .ser_sof(l_ser_sof), .ser_eof(l_ser_eof),
        .c_out(l_c_out), .frame_cnt(l_frame_cnt)
    );

    // Reference codeword: data nibble on top, parity = XOR of masked data
    function automatic logic [6:0] model_cw(input logic [3:0] d);
        return {d, ^(d & 4'b1011), ^(d & 4'b1101), ^(d & 4'b1110)};
    endfunction

    // Decoder-side syndrome as the downstream receiver computes it
    function automatic logic [2:0] syndrome(input logic [6:0] c);
        return {c[2] ^ c[6] ^ c[4] ^ c[3],
                c[1] ^ c[6] ^ c[5] ^ c[3],
                c[0] ^ c[6] ^ c[5] ^ c[4]};
    endfunction

    // Count of discrepancies between captured frames and the model
    function automatic int frame_errors();
        int e = 0;
        logic [6:0] cw;
        if (bit_m.size() != 7 * sent_q.size() || bit_l.size() != 7 * sent_q.size() ||
            cw_m.size() != sent_q.size() || cw_l.size() != sent_q.size())
            return 1000;
        for (int i = 0; i < sent_q.size(); i++) begin
            cw = model_cw(sent_q[i]);
            if (cw_m[i] !== cw) e++;
            if (cw_l[i] !== cw) e++;
            for (int j = 0; j < 7; j++) begin
                if (bit_m[7*i+j] !== cw[6-j]) e++;
                if (bit_l[7*i+j] !== cw[j]) e++;
                if (sof_m[7*i+j] !== (j == 0)) e++;
                if (eof_m[7*i+j] !== (j == 6)) e++;
            end
        end
        return e;
    endfunction

    task automatic do_reset();
        d_valid  = 1'b0;
        bit_tick = 1'b0;
        d_in     = 4'h0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive word_q through the DUTs and capture every consumed serial bit.
    // tick_mode 0 = random ticks, otherwise one tick every tick_mode cycles.
    task automatic run(input int tick_mode, input int max_cycles);
        int  idle = 0, cyc = 0, hold_l = 0;
        logic prev_v = 1'b0;
        sent_q.delete(); bit_m.delete(); bit_l.delete(); sof_m.delete();
        eof_m.delete(); held_l.delete(); cw_m.delete(); cw_l.delete();
        valid_m = 0; bursts_m = 0; rdy_low = 0; both_hi = 0; ready_diff = 0;
        timeout = 1'b0;
        forever begin
            if (tick_mode == 0) bit_tick = 1'($urandom_range(0, 1));
            else                bit_tick = ((cyc % tick_mode) == tick_mode - 1);
            d_valid = (word_q.size() > 0);
            d_in    = d_valid ? word_q[0] : 4'($urandom);
            if (d_valid && m_d_ready) sent_q.push_back(word_q.pop_front());
            if (!m_d_ready) rdy_low++;
            if (m_d_ready !== l_d_ready) ready_diff++;
            if ((m_ser_sof && m_ser_eof) || (l_ser_sof && l_ser_eof)) both_hi++;
            if (m_ser_valid) begin
                valid_m++;
                if (!prev_v) bursts_m++;
                if (bit_tick) begin
                    bit_m.push_back(m_ser_out);
                    sof_m.push_back(m_ser_sof);
                    eof_m.push_back(m_ser_eof);
                    if (m_ser_sof) cw_m.push_back(m_c_out);
                end
            end
            prev_v = m_ser_valid;
            if (l_ser_valid) begin
                hold_l++;
                if (bit_tick) begin
                    bit_l.push_back(l_ser_out);
                    held_l.push_back(hold_l);
                    hold_l = 0;
                    if (l_ser_sof) cw_l.push_back(l_c_out);
                end
            end
            if (word_q.size() == 0 && !m_ser_valid && !l_ser_valid && m_d_ready) idle++;
            else idle = 0;
            if (idle >= 4) break;
            if (cyc >= max_cycles) begin
                timeout = 1'b1;
                break;
            end
            cyc++;
            @(negedge clk);
        end
        d_valid  = 1'b0;
        bit_tick = 1'b0;
    endtask

    task automatic test_reset();
        d_valid = 1'b0; bit_tick = 1'b1; d_in = 4'hF; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_d_ready, m_ser_out, m_ser_valid, m_ser_sof, m_ser_eof, m_c_out, m_frame_cnt} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_msb: got %0h expected 0",
                     {m_d_ready, m_ser_out, m_ser_valid, m_ser_sof, m_ser_eof, m_c_out, m_frame_cnt});
        end
        n_checks++;
        if ({l_d_ready, l_ser_out, l_ser_valid, l_ser_sof, l_ser_eof, l_c_out, l_frame_cnt} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_lsb: got %0h expected 0",
                     {l_d_ready, l_ser_out, l_ser_valid, l_ser_sof, l_ser_eof, l_c_out, l_frame_cnt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_d_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", m_d_ready);
        end
        bit_tick = 1'b0;
    endtask

    task automatic test_encode();
        logic [6:0] got = '0;
        do_reset();
        word_q.push_back(4'b1011);
        run(1, 200);
        n_checks++;
        if (timeout !== 1'b0 || bit_m.size() != 7) begin
            n_fail++;
            $display("FAIL encode_done: got %0d bits expected 7 (timeout %b)", bit_m.size(), timeout);
        end else begin
            for (int j = 0; j < 7; j++) got[6-j] = bit_m[j];
            n_checks++;
            if (got !== 7'b1011100) begin
                n_fail++;
                $display("FAIL encode_serial: got %b expected 1011100", got);
            end
            n_checks++;
            if ({sof_m[0], eof_m[6], sof_m[6], eof_m[0]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL encode_markers: got %b expected 1100",
                         {sof_m[0], eof_m[6], sof_m[6], eof_m[0]});
            end
        end
        n_checks++;
        if (m_c_out !== 7'b1011100) begin
            n_fail++;
            $display("FAIL encode_c_out: got %b expected 1011100", m_c_out);
        end
        n_checks++;
        if (m_frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL encode_frame_cnt: got %0d expected 1", m_frame_cnt);
        end
    endtask

    task automatic test_loopback();
        int e;
        logic [7:0] fc0 = m_frame_cnt;
        for (int i = 0; i < 16; i++) word_q.push_back(4'(i));
        run(0, 3000);
        e = frame_errors();
        n_checks++;
        if (timeout !== 1'b0 || e !== 0) begin
            n_fail++;
            $display("FAIL loopback_frames: got %0d errors expected 0 (timeout %b)", e, timeout);
        end
        if (cw_m.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (syndrome(cw_m[i]) !== 3'd0 || cw_m[i][6:3] !== 4'(i)) begin
                    n_fail++;
                    $display("FAIL loopback_decode: got s=%b d=%h expected s=0 d=%h",
                             syndrome(cw_m[i]), cw_m[i][6:3], i);
                end
            end
            n_checks++;
            if ({cw_m[1], cw_m[15], cw_m[0]} !== {7'b0001110, 7'b1111111, 7'b0000000}) begin
                n_fail++;
                $display("FAIL loopback_spot: got %b %b %b expected 0001110 1111111 0000000",
                         cw_m[1], cw_m[15], cw_m[0]);
            end
        end else begin
            n_checks++; n_fail++;
            $display("FAIL loopback_count: got %0d frames expected 16", cw_m.size());
        end
        n_checks++;
        if (m_frame_cnt !== 8'(fc0 + 8'd16)) begin
            n_fail++;
            $display("FAIL loopback_frame_cnt: got %0d expected %0d", m_frame_cnt, 8'(fc0 + 8'd16));
        end
    endtask

    task automatic test_back_to_back();
        int e;
        for (int i = 0; i < 3; i++) word_q.push_back(4'($urandom));
        run(1, 300);
        e = frame_errors();
        n_checks++;
        if (timeout !== 1'b0 || e !== 0) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d errors expected 0", e);
        end
        n_checks++;
        if (valid_m !== 21 || bursts_m !== 1) begin
            n_fail++;
            $display("FAIL b2b_gapless: got %0d valid in %0d bursts expected 21 in 1", valid_m, bursts_m);
        end
        n_checks++;
        if (rdy_low !== 1 + 6 * 2) begin
            n_fail++;
            $display("FAIL b2b_ready_low: got %0d cycles expected 13", rdy_low);
        end
    endtask

    task automatic test_sparse();
        logic [6:0] got = '0;
        int bad_hold = 0;
        word_q.push_back(4'b0001);
        run(3, 300);
        n_checks++;
        if (timeout !== 1'b0 || bit_l.size() != 7) begin
            n_fail++;
            $display("FAIL sparse_done: got %0d bits expected 7", bit_l.size());
        end else begin
            for (int j = 0; j < 7; j++) got[j] = bit_l[j];
            for (int j = 1; j < 7; j++) if (held_l[j] != 3) bad_hold++;
            n_checks++;
            if (got !== 7'b0001110) begin
                n_fail++;
                $display("FAIL sparse_lsb_order: got c0..c6 %b%b%b%b%b%b%b expected 0111000",
                         got[0], got[1], got[2], got[3], got[4], got[5], got[6]);
            end
            n_checks++;
            if (bad_hold !== 0) begin
                n_fail++;
                $display("FAIL sparse_hold: got %0d bits not held 3 cycles expected 0", bad_hold);
            end
        end
    endtask

    task automatic test_random();
        int e;
        for (int i = 0; i < 30; i++) word_q.push_back(4'($urandom));
        run(0, 4000);
        e = frame_errors();
        n_checks++;
        if (timeout !== 1'b0 || e !== 0) begin
            n_fail++;
            $display("FAIL random_frames: got %0d errors expected 0", e);
        end
        n_checks++;
        if (both_hi !== 0 || ready_diff !== 0) begin
            n_fail++;
            $display("FAIL random_markers: got sof&eof %0d ready_diff %0d expected 0 0", both_hi, ready_diff);
        end
    endtask

    task automatic test_reset_midframe();
        logic [6:0] cw_a = model_cw(4'b1010);
        int seen = 0;
        do_reset();
        d_valid = 1'b1; d_in = 4'b1010; bit_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        d_in = 4'b0110;
        @(negedge clk);
        d_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_ser_valid, m_d_ready, m_ser_out} !== {1'b1, 1'b0, cw_a[3]}) begin
            n_fail++;
            $display("FAIL midframe_setup: got %b expected %b",
                     {m_ser_valid, m_d_ready, m_ser_out}, {1'b1, 1'b0, cw_a[3]});
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m_d_ready, m_ser_out, m_ser_valid, m_ser_sof, m_ser_eof, m_c_out, m_frame_cnt,
             l_d_ready, l_ser_out, l_ser_valid, l_ser_sof, l_ser_eof, l_c_out, l_frame_cnt} !== 38'd0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got %h expected 0",
                     {m_d_ready, m_ser_out, m_ser_valid, m_ser_sof, m_ser_eof, m_c_out, m_frame_cnt,
                      l_d_ready, l_ser_out, l_ser_valid, l_ser_sof, l_ser_eof, l_c_out, l_frame_cnt});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (m_ser_valid || l_ser_valid) seen++;
        end
        n_checks++;
        if (seen !== 0 || m_d_ready !== 1'b1 || m_frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midframe_residual: got valid=%0d ready=%b cnt=%0d expected 0 1 0",
                     seen, m_d_ready, m_frame_cnt);
        end
        bit_tick = 1'b0;
    endtask

    task automatic test_wrap();
        int e;
        do_reset();
        for (int i = 0; i < 256; i++) word_q.push_back(4'($urandom));
        run(1, 5000);
        e = frame_errors();
        n_checks++;
        if (timeout !== 1'b0 || e !== 0) begin
            n_fail++;
            $display("FAIL wrap_frames: got %0d errors expected 0", e);
        end
        n_checks++;
        if (m_frame_cnt !== 8'd0 || l_frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_frame_cnt: got %0d/%0d expected 0", m_frame_cnt, l_frame_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; d_valid = 1'b0; bit_tick = 1'b0; d_in = 4'h0;
        @(negedge clk);
        test_reset();
        test_encode();
        test_loopback();
        test_back_to_back();
        test_sparse();
        test_random();
        test_reset_midframe();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_enc_tx.md
# hamming_enc_tx

- Transmit-side Hamming(7,4) stage: accepts 4-bit data words over a valid/ready handshake and encodes each into a 7-bit codeword.
- Codewords are serialized one bit per `bit_tick`, with frame markers.
- Sits upstream of the channel feeding `hammingdec`; parity equations match that decoder's syndrome so a loopback yields s = 0.
- A one-word holding register plus a shift register give gap-free back-to-back frames.

## Interface
- `MSB_FIRST`, default 1: 1 = c[6] sent first; 0 = c[0] sent first.
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `d_in` input 4: data word {d3,d2,d1,d0}.
- `d_valid` input 1: `d_in` valid.
- `d_ready` output 1: block can accept; equals ~hold_full, no combinational path from `d_valid`.
- `bit_tick` input 1: advance serializer one bit on this edge.
- `ser_out` output 1: current serial bit.
- `ser_valid` output 1: `ser_out` carries a frame bit (state SHIFT).
- `ser_sof` output 1: high while first bit of a frame is on `ser_out`.
- `ser_eof` output 1: high while last bit of a frame is on `ser_out`.
- `c_out` output 7: parallel codeword currently in the shifter, for loopback checking.
- `frame_cnt` output 8: frames completed, wraps 255→0.

## Operation
- Encoding, codeword {c6..c0}:
  - c6=d3, c5=d2, c4=d1, c3=d0.
  - c2=d3^d0^d1.
  - c1=d3^d0^d2.
  - c0=d1^d2^d3.
- Accept when `d_valid && d_ready`; the encoded word is written to the hold register and hold_full is set.
- FSM states: IDLE, SHIFT.
- IDLE:
  - `ser_valid`=0, `ser_out`=0.
  - If hold_full: load shifter and `c_out` from hold, clear hold_full, bit index=0, go to SHIFT.
- SHIFT:
  - `ser_out` = bit selected by index per `MSB_FIRST`.
  - On `bit_tick`, index increments.
  - On `bit_tick` at index 6:
    - `frame_cnt` increments.
    - If hold_full: reload shifter, clear hold, index=0, stay in SHIFT (no idle cycle).
    - Else: go to IDLE.
- Simultaneous accept and load from hold on the same edge cannot occur, because `d_ready`=0 whenever hold_full=1.
- `bit_tick` in IDLE is ignored.
- Reset:
  - Applies on any edge with `rst_n`=0, including mid-frame: the frame is abandoned and hold is discarded.
  - All outputs go to 0: `d_ready`=0, `ser_*`=0, `c_out`=0, `frame_cnt`=0.
  - `d_ready` is forced 0 while `rst_n`=0 and rises on the first edge after release.

## Timing
- Accept at edge k → hold_full after k → shifter loaded at edge k+1 → `ser_valid`=1, `ser_sof`=1 during cycle after k+1.
- First-bit latency: 2 edges from accept.
- Each bit is held until the edge where `bit_tick`=1. A frame is exactly 7 ticks.
- `d_ready` re-asserts the cycle after the hold drains into the shifter.
- With `bit_tick` tied high, a new word can be accepted during every frame, giving continuous output at 7 cycles/frame.
- `ser_eof` and `ser_sof` are never both high.
- `frame_cnt` updates on the edge that consumes bit 6.

## Structure
- Shared package `hamming_pkg`, also used by `hammingdec`, holds:
  - Constants N=7 and K=4.
  - The parity/encode function.
  - Bit-position constants for d0..d3 at 3..6.
- Sub-module `hamming74_enc`: purely combinational 4→7 encoder, instantiated once on the accept path.
- FSM and serializer stay in the top module.

## Test plan
- Encode check, `d_in`=4'b1011 → `c_out`=7'b1011100. With `MSB_FIRST`=1 and `bit_tick`=1, `ser_out` sequence is 1,0,1,1,1,0,0; `ser_sof` on bit 1, `ser_eof` on bit 7; `frame_cnt`=1.
- Exhaustive loopback: all 16 `d_in` values through `c_out` into `hammingdec` give s=0 and d=`d_in`. Spot checks: 4'b0001 → 7'b0001110, 4'b1111 → 7'b1111111, 4'b0000 → 7'b0000000.
- Back-to-back: `d_valid` held high with 3 words and `bit_tick`=1 → 21 consecutive `ser_valid` cycles with no gap; `d_ready` low only while hold is full.
- Sparse ticks: `bit_tick` every 3rd cycle, `d_in`=4'b0001, `MSB_FIRST`=0 → each bit held 3 cycles; order 0,1,1,1,0,0,0.
- Reset mid-frame: assert `rst_n`=0 at bit 3 with hold full → next cycle all outputs 0, `frame_cnt`=0; after release `d_ready`=1 and no residual frame is emitted.
- Wrap: 256 frames → `frame_cnt` returns to 0.
